// File: rtl/adc_seq_pkg.sv
// Shared types and constants for the LTC2308 scan sequencer.
// Contents: channel/data widths and the sequencer FSM state encoding.
package adc_seq_pkg;

  localparam int unsigned NUM_CH = 8;
  localparam int unsigned CH_W   = 3;
  localparam int unsigned DATA_W = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    EMIT  = 2'd3
  } state_t;

endpackage

// File: rtl/adc_seq_chsel.sv
// Channel selector: combinational priority search over a channel mask.
// Ports:
//   mask    - enabled channels, bit n = channel n
//   cur_ch  - channel of the transaction in progress
//   next_ch - lowest enabled channel strictly above cur_ch (valid when !last)
//   low_ch  - lowest enabled channel in mask
//   last    - no enabled channel above cur_ch
module adc_seq_chsel
  import adc_seq_pkg::*;
(
  input  logic [NUM_CH-1:0] mask,
  input  logic [CH_W-1:0]   cur_ch,
  output logic [CH_W-1:0]   next_ch,
  output logic [CH_W-1:0]   low_ch,
  output logic              last
);

  // Descending walk so the final hit is the lowest qualifying channel.
  always_comb begin
    next_ch = '0;
    low_ch  = '0;
    last    = 1'b1;
    for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
      if (mask[i]) begin
        low_ch = CH_W'(i);
        if (CH_W'(i) > cur_ch) begin
          next_ch = CH_W'(i);
          last    = 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/adc_scan_sequencer.sv
// Scan sequencer for the adc_ltc2308 SPI core. Periodically converts every
// enabled channel, services one-shot requests between scans, and re-tags
// results with the channel of the previous transaction (the LTC2308 returns
// the result configured one transaction earlier).
// Ports:
//   adc_clk, reset          - clock, async active-high reset
//   enable                  - periodic scanning allowed while high
//   ch_mask, scan_period    - scan channel set and trigger period
//   os_req, os_ch, os_ack   - one-shot request handshake
//   measure_start/_ch       - transaction request to the core
//   measure_done/_dataread  - completion level and data from the core
//   res_valid/_ch/_data/_os - tagged result strobe
//   scan_done, busy         - scan completion pulse, not-idle status
//   overrun, timeout_err    - sticky error flags
module adc_scan_sequencer
  import adc_seq_pkg::*;
#(
  parameter int unsigned PERIOD_W = 16,
  parameter int unsigned TIMEOUT  = 1023
) (
  input  logic                adc_clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [NUM_CH-1:0]   ch_mask,
  input  logic [PERIOD_W-1:0] scan_period,
  input  logic                os_req,
  input  logic [CH_W-1:0]     os_ch,
  output logic                os_ack,
  output logic                measure_start,
  output logic [CH_W-1:0]     measure_ch,
  input  logic                measure_done,
  input  logic [DATA_W-1:0]   measure_dataread,
  output logic                res_valid,
  output logic [CH_W-1:0]     res_ch,
  output logic [DATA_W-1:0]   res_data,
  output logic                res_os,
  output logic                scan_done,
  output logic                busy,
  output logic                overrun,
  output logic                timeout_err
);

  localparam int unsigned TO_W = $clog2(TIMEOUT + 1);

  state_t state, state_n;

  logic [PERIOD_W-1:0] timer;
  logic                scan_pending;
  logic                trigger;
  logic                done_q;
  logic                done_rise;
  logic                grant_os;
  logic                grant_scan;
  logic                consume;
  logic                timed_out;

  logic [NUM_CH-1:0]   mask_q, sel_mask;
  logic [CH_W-1:0]     next_ch, low_ch;
  logic                last;

  // Tag pipeline: channel of the previous transaction and priming flag.
  logic [CH_W-1:0]     tag_ch;
  logic                priming;
  logic                is_os;
  logic                final_txn;
  logic [TO_W-1:0]     wait_cnt;

  logic                os_ack_d, measure_start_d, res_valid_d, res_os_d;
  logic                scan_done_d, busy_d, timeout_err_d;
  logic [CH_W-1:0]     measure_ch_d, res_ch_d, tag_ch_d;
  logic [DATA_W-1:0]   res_data_d;
  logic [NUM_CH-1:0]   mask_q_d;
  logic                priming_d, is_os_d, final_txn_d;
  logic [TO_W-1:0]     wait_cnt_d;

  assign trigger    = enable && (timer == '0);
  assign consume    = (state == IDLE) && !os_req && scan_pending;
  assign grant_os   = (state == IDLE) && os_req;
  assign grant_scan = consume && (ch_mask != '0);
  assign done_rise  = measure_done && !done_q;
  assign timed_out  = (state == WAIT) && !done_rise && (wait_cnt >= TO_W'(TIMEOUT));
  // In IDLE the live mask feeds the selector so the first channel is known at grant.
  assign sel_mask   = (state == IDLE) ? ch_mask : mask_q;

  adc_seq_chsel u_chsel (
    .mask    (sel_mask),
    .cur_ch  (measure_ch),
    .next_ch (next_ch),
    .low_ch  (low_ch),
    .last    (last)
  );

  // Period timer, single pending trigger and overrun detection.
  always_ff @(posedge adc_clk or posedge reset) begin
    if (reset) begin
      timer        <= '0;
      scan_pending <= 1'b0;
      overrun      <= 1'b0;
    end else if (!enable) begin
      timer        <= '0;
      scan_pending <= 1'b0;
    end else begin
      timer        <= trigger ? scan_period : timer - PERIOD_W'(1);
      scan_pending <= trigger || (scan_pending && !consume);
      if (trigger && scan_pending && !consume) overrun <= 1'b1;
    end
  end

  // measure_done edge detector.
  always_ff @(posedge adc_clk or posedge reset) begin
    if (reset) done_q <= 1'b0;
    else       done_q <= measure_done;
  end

  // State register.
  always_ff @(posedge adc_clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Next-state logic.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:  if (grant_os || grant_scan) state_n = START;
      START: state_n = WAIT;
      WAIT:  begin
        if (done_rise)      state_n = EMIT;
        else if (timed_out) state_n = IDLE;
      end
      EMIT:  state_n = final_txn ? IDLE : START;
      default: state_n = IDLE;
    endcase
  end

  // Output and datapath next values; registered below.
  always_comb begin
    os_ack_d        = 1'b0;
    measure_start_d = 1'b0;
    res_valid_d     = 1'b0;
    scan_done_d     = 1'b0;
    busy_d          = (state_n != IDLE);
    timeout_err_d   = timeout_err;
    measure_ch_d    = measure_ch;
    res_ch_d        = res_ch;
    res_data_d      = res_data;
    res_os_d        = res_os;
    tag_ch_d        = tag_ch;
    mask_q_d        = mask_q;
    priming_d       = priming;
    is_os_d         = is_os;
    final_txn_d     = final_txn;
    wait_cnt_d      = wait_cnt;
    case (state)
      IDLE: begin
        if (grant_os) begin
          os_ack_d        = 1'b1;
          measure_start_d = 1'b1;
          measure_ch_d    = os_ch;
          tag_ch_d        = measure_ch;
          priming_d       = 1'b1;
          is_os_d         = 1'b1;
          final_txn_d     = 1'b0;
        end else if (grant_scan) begin
          measure_start_d = 1'b1;
          measure_ch_d    = low_ch;
          tag_ch_d        = measure_ch;
          mask_q_d        = ch_mask;
          priming_d       = 1'b1;
          is_os_d         = 1'b0;
          final_txn_d     = 1'b0;
        end
      end
      START: wait_cnt_d = TO_W'(1);
      WAIT: begin
        if (done_rise) begin
          res_valid_d = !priming;
          res_ch_d    = tag_ch;
          res_data_d  = measure_dataread;
          res_os_d    = is_os;
          priming_d   = 1'b0;
        end else if (timed_out) begin
          timeout_err_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt + TO_W'(1);
        end
      end
      EMIT: begin
        if (!final_txn) begin
          measure_start_d = 1'b1;
          tag_ch_d        = measure_ch;
          if (is_os) begin
            final_txn_d = 1'b1;
          end else if (last) begin
            // Flush transaction re-addresses the lowest channel.
            measure_ch_d = low_ch;
            final_txn_d  = 1'b1;
          end else begin
            measure_ch_d = next_ch;
          end
        end else begin
          scan_done_d = !is_os;
        end
      end
      default: ;
    endcase
  end

  // Registered outputs and transaction context.
  always_ff @(posedge adc_clk or posedge reset) begin
    if (reset) begin
      os_ack        <= 1'b0;
      measure_start <= 1'b0;
      measure_ch    <= '0;
      res_valid     <= 1'b0;
      res_ch        <= '0;
      res_data      <= '0;
      res_os        <= 1'b0;
      scan_done     <= 1'b0;
      busy          <= 1'b0;
      timeout_err   <= 1'b0;
      tag_ch        <= '0;
      mask_q        <= '0;
      priming       <= 1'b0;
      is_os         <= 1'b0;
      final_txn     <= 1'b0;
      wait_cnt      <= '0;
    end else begin
      os_ack        <= os_ack_d;
      measure_start <= measure_start_d;
      measure_ch    <= measure_ch_d;
      res_valid     <= res_valid_d;
      res_ch        <= res_ch_d;
      res_data      <= res_data_d;
      res_os        <= res_os_d;
      scan_done     <= scan_done_d;
      busy          <= busy_d;
      timeout_err   <= timeout_err_d;
      tag_ch        <= tag_ch_d;
      mask_q        <= mask_q_d;
      priming       <= priming_d;
      is_os         <= is_os_d;
      final_txn     <= final_txn_d;
      wait_cnt      <= wait_cnt_d;
    end
  end

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Self-checking bench for adc_scan_sequencer: LTC2308 core model returning the
// previously configured channel's value, scoreboard queues for transactions
// and results, and directed/randomized scenarios.
module tb_adc_scan_sequencer;

  localparam int unsigned TIMEOUT = 1023;

  logic        adc_clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [7:0]  ch_mask;
  logic [15:0] scan_period;
  logic        os_req;
  logic [2:0]  os_ch;
  logic        os_ack;
  logic        measure_start;
  logic [2:0]  measure_ch;
  logic        measure_done;
  logic [11:0] measure_dataread;
  logic        res_valid;
  logic [2:0]  res_ch;
  logic [11:0] res_data;
  logic        res_os;
  logic        scan_done;
  logic        busy;
  logic        overrun;
  logic        timeout_err;

  always #5 adc_clk = ~adc_clk;

  adc_scan_sequencer #(.PERIOD_W(16), .TIMEOUT(TIMEOUT)) dut (
    .adc_clk          (adc_clk),
    .reset            (reset),
    .enable           (enable),
    .ch_mask          (ch_mask),
    .scan_period      (scan_period),
    .os_req           (os_req),
    .os_ch            (os_ch),
    .os_ack           (os_ack),
    .measure_start    (measure_start),
    .measure_ch       (measure_ch),
    .measure_done     (measure_done),
    .measure_dataread (measure_dataread),
    .res_valid        (res_valid),
    .res_ch           (res_ch),
    .res_data         (res_data),
    .res_os           (res_os),
    .scan_done        (scan_done),
    .busy             (busy),
    .overrun          (overrun),
    .timeout_err      (timeout_err)
  );

  typedef struct packed {
    logic [2:0]  ch;
    logic [11:0] data;
    logic        os;
  } res_t;

  res_t        exp_res[$];
  logic [2:0]  exp_txn[$];
  int          done_cyc[$];
  logic [11:0] adc_val[8];

  int n_chk = 0, n_fail = 0;
  int cyc = 0, start_cnt = 0, res_cnt = 0, done_cnt = 0, ack_cnt = 0;
  int last_start_cyc = 0, to_cyc = 0;
  logic to_prev = 1'b0;
  int lat_fix = 3;
  bit lat_rand = 1'b0;
  bit hang = 1'b0;
  res_t er;
  logic [2:0] et;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [2:0] lowest(input logic [7:0] m);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 7; i >= 0; i--) if (m[i]) r = 3'(i);
    return r;
  endfunction

  // Scan of mask m: ascending enabled channels then a flush on the lowest;
  // result k is channel k's value tagged with channel k.
  task automatic push_scan(input logic [7:0] m);
    for (int i = 0; i < 8; i++) begin
      if (m[i]) begin
        exp_txn.push_back(3'(i));
        exp_res.push_back('{ch: 3'(i), data: adc_val[i], os: 1'b0});
      end
    end
    exp_txn.push_back(lowest(m));
  endtask

  task automatic push_os(input logic [2:0] ch);
    exp_txn.push_back(ch);
    exp_txn.push_back(ch);
    exp_res.push_back('{ch: ch, data: adc_val[ch], os: 1'b1});
  endtask

  task automatic randomize_vals();
    for (int i = 0; i < 8; i++) adc_val[i] = 12'($urandom);
  endtask

  task automatic wait_done_cnt(input int target, input int budget, input string name);
    int t;
    t = 0;
    while (done_cnt < target && t < budget) begin
      @(negedge adc_clk);
      t++;
    end
    chk({name, "_in_time"}, int'(done_cnt >= target), 1);
  endtask

  task automatic wait_idle(input string name);
    int t;
    t = 0;
    while ((busy || exp_txn.size() != 0 || exp_res.size() != 0) && t < 3000) begin
      @(negedge adc_clk);
      t++;
    end
    repeat (3) @(negedge adc_clk);
    chk({name, "_txn_left"}, exp_txn.size(), 0);
    chk({name, "_res_left"}, exp_res.size(), 0);
    chk({name, "_busy"}, int'(busy), 0);
  endtask

  // Monitor / scoreboard.
  always @(negedge adc_clk) begin
    cyc++;
    if (timeout_err && !to_prev) to_cyc = cyc;
    to_prev = timeout_err;
    if (!reset) begin
      if (measure_start) begin
        start_cnt++;
        last_start_cyc = cyc;
        if (exp_txn.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL txn_unexpected: measure_ch=%0d, none expected", measure_ch);
        end else begin
          et = exp_txn.pop_front();
          chk("txn_ch", int'(measure_ch), int'(et));
        end
      end
      if (res_valid) begin
        res_cnt++;
        if (exp_res.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL res_unexpected: ch=%0d data=0x%0h os=%0d, none expected",
                   res_ch, res_data, res_os);
        end else begin
          er = exp_res.pop_front();
          chk("res_ch", int'(res_ch), int'(er.ch));
          chk("res_data", int'(res_data), int'(er.data));
          chk("res_os", int'(res_os), int'(er.os));
        end
      end
      if (scan_done) begin
        done_cnt++;
        done_cyc.push_back(cyc);
      end
      if (os_ack) ack_cnt++;
    end
  end

  // LTC2308 core model: result returned is for the previously configured channel.
  initial begin
    int cnt;
    bit active;
    logic [2:0] cfg, prev;
    measure_done = 1'b0;
    measure_dataread = '0;
    cnt = 0;
    active = 1'b0;
    cfg = '0;
    prev = '0;
    forever begin
      @(negedge adc_clk);
      if (measure_start && !reset) begin
        cfg = measure_ch;
        active = 1'b1;
        measure_done = 1'b0;
        cnt = lat_rand ? int'($urandom_range(6, 1)) : lat_fix;
      end else if (active && !hang) begin
        if (cnt <= 1) begin
          measure_done = 1'b1;
          measure_dataread = adc_val[prev];
          prev = cfg;
          active = 1'b0;
        end else begin
          cnt--;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_done, base_res, base_start, base_ack, t, dlt;
    logic [7:0] m;
    logic [2:0] osc;
    bit busy_seen;

    reset = 1'b1;
    enable = 1'b0;
    ch_mask = '0;
    scan_period = '0;
    os_req = 1'b0;
    os_ch = '0;
    for (int i = 0; i < 8; i++) adc_val[i] = 12'h100 + 12'(i);
    repeat (3) @(negedge adc_clk);
    chk("rst_os_ack", int'(os_ack), 0);
    chk("rst_measure_start", int'(measure_start), 0);
    chk("rst_measure_ch", int'(measure_ch), 0);
    chk("rst_res_valid", int'(res_valid), 0);
    chk("rst_res_ch", int'(res_ch), 0);
    chk("rst_res_data", int'(res_data), 0);
    chk("rst_res_os", int'(res_os), 0);
    chk("rst_scan_done", int'(scan_done), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_overrun", int'(overrun), 0);
    chk("rst_timeout_err", int'(timeout_err), 0);
    reset = 1'b0;
    repeat (2) @(negedge adc_clk);

    // Periodic scans, mask 0x05, period 100, fixed latency.
    ch_mask = 8'h05;
    scan_period = 16'd100;
    lat_rand = 1'b0;
    lat_fix = 3;
    repeat (3) push_scan(8'h05);
    base_done = done_cnt;
    done_cyc.delete();
    enable = 1'b1;
    wait_done_cnt(base_done + 3, 500, "periodic");
    enable = 1'b0;
    if (done_cyc.size() >= 3) begin
      chk("trigger_interval_a", done_cyc[1] - done_cyc[0], 101);
      chk("trigger_interval_b", done_cyc[2] - done_cyc[1], 101);
    end else begin
      n_chk++;
      n_fail++;
      $display("FAIL trigger_interval: only %0d scan_done pulses", done_cyc.size());
    end
    wait_idle("periodic");
    chk("periodic_done_count", done_cnt - base_done, 3);

    // One-shot on channel 5 while idle.
    lat_rand = 1'b1;
    randomize_vals();
    base_ack = ack_cnt;
    push_os(3'd5);
    os_ch = 3'd5;
    os_req = 1'b1;
    t = 0;
    while (!os_ack && t < 50) begin
      @(negedge adc_clk);
      t++;
    end
    chk("os_ack_seen", int'(os_ack), 1);
    chk("os_ack_with_start", int'(measure_start), 1);
    os_req = 1'b0;
    wait_idle("oneshot");
    chk("os_ack_count", ack_cnt - base_ack, 1);

    // One-shot raised mid-scan (mask 0xFF); enable dropped mid-scan too.
    randomize_vals();
    ch_mask = 8'hFF;
    scan_period = 16'd200;
    push_scan(8'hFF);
    base_done = done_cnt;
    base_res = res_cnt;
    base_start = start_cnt;
    enable = 1'b1;
    t = 0;
    while (start_cnt == base_start && t < 20) begin
      @(negedge adc_clk);
      t++;
    end
    osc = 3'($urandom_range(7, 0));
    push_os(osc);
    os_ch = osc;
    os_req = 1'b1;
    enable = 1'b0;
    t = 0;
    while (!os_ack && t < 400) begin
      @(negedge adc_clk);
      t++;
    end
    chk("midscan_os_ack_seen", int'(os_ack), 1);
    chk("os_after_scan_done", done_cnt - base_done, 1);
    os_req = 1'b0;
    wait_idle("midscan");
    chk("midscan_res_count", res_cnt - base_res, 9);

    // Timeout: core never completes; next trigger must still proceed.
    randomize_vals();
    m = 8'($urandom_range(255, 1));
    ch_mask = m;
    scan_period = 16'd1100;
    exp_txn.push_back(lowest(m));
    hang = 1'b1;
    base_res = res_cnt;
    base_done = done_cnt;
    enable = 1'b1;
    t = 0;
    while (!timeout_err && t < 1200) begin
      @(negedge adc_clk);
      t++;
    end
    chk("timeout_flag", int'(timeout_err), 1);
    @(negedge adc_clk);
    dlt = to_cyc - last_start_cyc;
    n_chk++;
    if (dlt < int'(TIMEOUT) || dlt > int'(TIMEOUT) + 2) begin
      n_fail++;
      $display("FAIL timeout_latency: got %0d cycles, expected %0d..%0d", dlt, TIMEOUT, TIMEOUT + 2);
    end
    chk("timeout_idle", int'(busy), 0);
    chk("timeout_no_result", res_cnt - base_res, 0);
    hang = 1'b0;
    push_scan(m);
    wait_done_cnt(base_done + 1, 400, "after_timeout");
    enable = 1'b0;
    wait_idle("after_timeout");
    chk("timeout_sticky", int'(timeout_err), 1);
    chk("no_overrun_yet", int'(overrun), 0);

    // Back-to-back scans with slow core: overrun during the first scan.
    m = 8'($urandom_range(255, 1));
    ch_mask = m;
    scan_period = 16'd0;
    lat_rand = 1'b0;
    lat_fix = 50;
    push_scan(m);
    base_done = done_cnt;
    enable = 1'b1;
    t = 0;
    while (!overrun && t < 20) begin
      @(negedge adc_clk);
      t++;
    end
    enable = 1'b0;
    chk("overrun_set", int'(overrun), 1);
    chk("overrun_in_first_scan", int'(busy), 1);
    wait_done_cnt(base_done + 1, 1000, "overrun_scan");
    wait_idle("overrun_scan");
    chk("overrun_done_count", done_cnt - base_done, 1);

    // Empty mask: triggers consumed, nothing issued.
    ch_mask = 8'h00;
    base_start = start_cnt;
    base_done = done_cnt;
    busy_seen = 1'b0;
    enable = 1'b1;
    repeat (40) begin
      @(negedge adc_clk);
      if (busy) busy_seen = 1'b1;
    end
    enable = 1'b0;
    chk("mask0_no_start", start_cnt - base_start, 0);
    chk("mask0_no_done", done_cnt - base_done, 0);
    chk("mask0_never_busy", int'(busy_seen), 0);

    // Reset while waiting on the core.
    lat_fix = 20;
    m = 8'($urandom_range(255, 1));
    ch_mask = m;
    scan_period = 16'd500;
    exp_txn.push_back(lowest(m));
    base_start = start_cnt;
    enable = 1'b1;
    t = 0;
    while (start_cnt == base_start && t < 20) begin
      @(negedge adc_clk);
      t++;
    end
    repeat (5) @(negedge adc_clk);
    reset = 1'b1;
    enable = 1'b0;
    #1;
    chk("rstmid_busy", int'(busy), 0);
    chk("rstmid_measure_ch", int'(measure_ch), 0);
    chk("rstmid_timeout_err", int'(timeout_err), 0);
    chk("rstmid_overrun", int'(overrun), 0);
    chk("rstmid_res_data", int'(res_data), 0);
    @(negedge adc_clk);
    reset = 1'b0;
    base_res = res_cnt;
    repeat (40) @(negedge adc_clk);
    chk("rstmid_no_result", res_cnt - base_res, 0);
    randomize_vals();
    push_scan(m);
    base_done = done_cnt;
    enable = 1'b1;
    wait_done_cnt(base_done + 1, 600, "after_reset");
    enable = 1'b0;
    wait_idle("after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/adc_scan_sequencer.md
# adc_scan_sequencer

Scan sequencer for the LTC2308 SPI core (`adc_ltc2308`): periodically converts every enabled channel, services one-shot conversion requests between scans, and re-tags results with the correct channel, since the LTC2308 returns the result for the channel configured in the previous transaction. It sits between the host register bank and the `adc_ltc2308` core and replaces the inline start/count logic of the FIFO wrapper.

## Interface

Parameters:
- `PERIOD_W`, 16: width of the scan period counter.
- `TIMEOUT`, 1023: maximum `adc_clk` cycles allowed from `measure_start` to `measure_done` before a transaction is aborted.

Ports:
- `adc_clk`  in  1  single clock, max 40 MHz.
- `reset`  in  1  asynchronous, active-high.
- `enable`  in  1  level; periodic scanning is allowed while high.
- `ch_mask`  in  8  enabled channels, bit n = channel n.
- `scan_period`  in  PERIOD_W  cycles between scan triggers; 0 means back-to-back scans.
- `os_req`  in  1  one-shot request, level; held until `os_ack`.
- `os_ch`  in  3  one-shot channel; stable while `os_req` is high.
- `os_ack`  out  1  one-cycle pulse when the one-shot is accepted.
- `measure_start`  out  1  to the core; one-cycle pulse.
- `measure_ch`  out  3  to the core; config channel for this transaction.
- `measure_done`  in  1  from the core; level, cleared by the core after the next start.
- `measure_dataread`  in  12  from the core.
- `res_valid`  out  1  one-cycle result strobe.
- `res_ch`  out  3  channel of `res_data`.
- `res_data`  out  12  conversion result.
- `res_os`  out  1  result belongs to a one-shot.
- `scan_done`  out  1  one-cycle pulse after the last result of a scan.
- `busy`  out  1  high whenever the sequencer is not in IDLE.
- `overrun`  out  1  sticky; set when a scan trigger occurs while a previous trigger is still pending.
- `timeout_err`  out  1  sticky; set on transaction timeout.

## Operation

- **Period timer.** The timer runs while `enable` is high. It reloads to `scan_period` and sets `scan_pending` on expiry. With `enable` low, the timer is held at 0 and `scan_pending` is cleared.
- **Arbitration in IDLE.** `os_req` takes priority over `scan_pending`. Scans are never preempted; a one-shot waits for scan completion.
- **Scan.** At scan start, `ch_mask` is latched. Transactions are issued in ascending channel order for the enabled channels, then one flush transaction with `measure_ch` = lowest enabled channel. A scan therefore has popcount(mask)+1 transactions.
  - The first transaction's data is discarded (priming).
  - Result k is tagged with the channel of transaction k−1.
  - `ch_mask`==0: the trigger is consumed, nothing is issued, and `scan_done` is not pulsed.
- **One-shot.** `os_ack` is pulsed on acceptance. Two transactions are issued, both with `os_ch`; only the second result is emitted, with `res_os`=1.
- **FSM.**
  - IDLE → START on grant.
  - START: `measure_start`=1 for one cycle → WAIT.
  - WAIT: on the rising edge of `measure_done` → EMIT. On timeout → IDLE, set `timeout_err`, and drop the scan or one-shot.
  - EMIT: raise `res_valid` if the result is not priming. Go to START if transactions remain, else go to IDLE and pulse `scan_done` for a scan.
- **Enable deasserted mid-scan.** The current scan, including the flush, completes.
- **Reset mid-operation.** All state returns to IDLE. The in-flight core transaction is abandoned, and its `measure_done` edge is ignored because WAIT is not entered.

## Timing

- Reset values: every output is 0; `res_ch`/`res_data` are 0; `measure_ch` is 0.
- `measure_ch` is valid from the START cycle and held until the next START.
- `res_*` outputs are registered. `res_valid` is asserted 1 cycle after the first cycle `measure_done` is sampled high. `res_data`/`res_ch` are held until the next `res_valid`.
- `scan_done` asserts in the cycle after the final `res_valid`.
- Minimum gap between transactions is 2 cycles (EMIT→START).
- Timer: with `scan_period`=P, triggers occur every P+1 cycles.
- A trigger while `scan_pending` is already set sets `overrun`. The pending flag stays single; triggers are not queued.
- `os_ack` coincides with the first START cycle of the one-shot.
- Sticky flags clear only on `reset`.

## Structure

- Package `adc_seq_pkg`: FSM state enum (IDLE, START, WAIT, EMIT), `NUM_CH`=8, `CH_W`=3, `DATA_W`=12.
- Sub-module `adc_seq_chsel`: given the latched mask and current channel, returns the next enabled channel, the lowest enabled channel, and a last flag (combinational priority search).
- The timer, FSM, and tag pipeline (previous channel, priming flag) live in the top level.

## Test plan

- `ch_mask`=8'b0000_0101, `scan_period`=100, core model returns 12'h100+ch: 3 transactions with `measure_ch` 0,2,0. `res_valid` ×2 gives (ch0,0x100) then (ch2,0x102). `scan_done` pulses once. Triggers repeat every 101 cycles.
- `os_req` with `os_ch`=5 while idle: `os_ack` pulses, 2 transactions on ch5, one result (ch5,0x105,`res_os`=1).
- `os_req` raised mid-scan with mask 0xFF: the scan completes with 8 results, then the one-shot runs; `os_ack` comes after `scan_done`.
- Core model holds `measure_done` low: after 1023 cycles the sequencer returns to IDLE, `timeout_err`=1, no `res_valid`, and the next trigger proceeds.
- `scan_period`=0 with a core latency of 50 cycles: `overrun` sets during the first scan. `ch_mask`=0 produces no `measure_start` at all.
- `reset` asserted in WAIT: outputs go to 0 immediately. A subsequent `measure_done` edge produces no `res_valid`, and a fresh scan starts with priming.
